// File: rtl/hamming_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hamming_pkg                                                     |
// | Purpose  : Shared (16,11) SECDED layout for the encoder and decoder LUTs.  |
// |            Code bit n of {MSW,LSW} is Hamming position n. p0 sits at 0,    |
// |            p1/p2/p4/p8 sit at the power-of-two positions, and data bits    |
// |            b1..b11 fill the rest in ascending order.                       |
// | Contents : state_t FSM encoding, data/code widths, parity positions and   |
// |            parity coverage masks.                                          |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_LSW = 3'd1,
    ST_RD_MSW = 3'd2,
    ST_CAPT   = 3'd3,
    ST_WR_LSW = 3'd4,
    ST_WR_MSW = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam int c_data_w = 11;
  localparam int c_code_w = 16;

  // Parity bit positions inside the 16-bit code word.
  localparam int c_pos_p1 = 1;
  localparam int c_pos_p2 = 2;
  localparam int c_pos_p4 = 4;
  localparam int c_pos_p8 = 8;

  // Parity pK covers every position whose index has bit K set.
  localparam logic [15:0] c_cover_p1 = 16'hAAAA;
  localparam logic [15:0] c_cover_p2 = 16'hCCCC;
  localparam logic [15:0] c_cover_p4 = 16'hF0F0;
  localparam logic [15:0] c_cover_p8 = 16'hFF00;

endpackage
`default_nettype wire

// File: rtl/hamming_parity_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hamming_parity_gen                                              |
// | Purpose  : Combinational (16,11) SECDED encoder.                           |
// | Ports    : i_data [10:0] message bits b11..b1 (bit 0 = b1)                 |
// |            o_code [15:0] {MSW, LSW} code word in positional layout         |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [c_data_w-1:0] i_data,
  output logic [c_code_w-1:0] o_code
);

  logic [c_code_w-1:0] w_placed;
  logic [c_code_w-1:0] w_hamming;

  // Data bits go to the non-power-of-two positions. Parity slots stay 0.
  always_comb begin
    w_placed        = '0;
    w_placed[3]     = i_data[0];
    w_placed[7:5]   = i_data[3:1];
    w_placed[15:9]  = i_data[10:4];
  end

  // Parity slots are 0 in w_placed, so masking with the coverage set gives
  // exactly the data bits that each parity protects.
  always_comb begin
    w_hamming           = w_placed;
    w_hamming[c_pos_p1] = ^(w_placed & c_cover_p1);
    w_hamming[c_pos_p2] = ^(w_placed & c_cover_p2);
    w_hamming[c_pos_p4] = ^(w_placed & c_cover_p4);
    w_hamming[c_pos_p8] = ^(w_placed & c_cover_p8);
  end

  // Overall even parity. Bit 0 of w_hamming is still 0, so reducing the
  // whole vector equals reducing bits 15:1.
  assign o_code = {w_hamming[15:1], ^w_hamming};

endmodule
`default_nettype wire

// File: rtl/hamming_encoder_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hamming_encoder_fsm                                             |
// | Purpose  : Memory-master sequencer. It reads NUM_WORDS 11-bit messages     |
// |            (two bytes each), SECDED-encodes them and writes the 16-bit     |
// |            codes back as two bytes, then holds done.                       |
// | Ports    : Clk          rising-edge clock                                  |
// |            Reset        asynchronous active-low reset                      |
// |            start        1-cycle pulse, honoured only in IDLE/DONE          |
// |            busy/done    run status (registered)                            |
// |            mem_addr     byte address for read or write                     |
// |            mem_rd_data  sync-read data, valid one cycle after mem_addr     |
// |            mem_wr_en    one-byte write strobe                              |
// |            mem_wr_data  write data                                         |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module hamming_encoder_fsm
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int IN_BASE   = 0,
  parameter int OUT_BASE  = 30,
  parameter int AW        = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam int            CW         = $clog2(NUM_WORDS + 1);
  localparam logic [AW-1:0] c_in_base  = AW'(IN_BASE);
  localparam logic [AW-1:0] c_out_base = AW'(OUT_BASE);
  localparam logic [CW-1:0] c_last     = CW'(NUM_WORDS - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_lsw;
  logic [2:0]    r_msw;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_addr;
  logic          r_wr_en;
  logic [7:0]    r_wr_data;

  logic [AW-1:0] w_off;
  logic [2:0]    w_msw_bits;
  logic [15:0]   w_code;

  // Byte offset 2*i. Address sums wrap modulo 2^AW.
  assign w_off = AW'({r_cnt, 1'b0});

  // The code LSW is registered on the CAPT->WR_LSW edge, while the MSW byte
  // is still on the read bus. So the parity input takes the MSW bits straight
  // from the bus in CAPT, and from the capture register afterwards.
  assign w_msw_bits = (r_state == ST_CAPT) ? mem_rd_data[2:0] : r_msw;

  hamming_parity_gen u_parity (
    .i_data ({w_msw_bits, r_lsw}),
    .o_code (w_code)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lsw     <= '0;
      r_msw     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      // Memory outputs are idle unless a state below drives them.
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RD_LSW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_addr  <= c_in_base;
          end
        end
        ST_RD_LSW: begin
          r_state <= ST_RD_MSW;
          r_addr  <= c_in_base + w_off + AW'(1);
        end
        ST_RD_MSW: begin
          r_state <= ST_CAPT;
          r_lsw   <= mem_rd_data;
        end
        ST_CAPT: begin
          r_state   <= ST_WR_LSW;
          r_msw     <= mem_rd_data[2:0];
          r_wr_en   <= 1'b1;
          r_addr    <= c_out_base + w_off;
          r_wr_data <= w_code[7:0];
        end
        ST_WR_LSW: begin
          r_state   <= ST_WR_MSW;
          r_wr_en   <= 1'b1;
          r_addr    <= c_out_base + w_off + AW'(1);
          r_wr_data <= w_code[15:8];
        end
        ST_WR_MSW: begin
          if (r_cnt == c_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RD_LSW;
            r_cnt   <= r_cnt + CW'(1);
            r_addr  <= c_in_base + w_off + AW'(2);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_addr    = r_addr;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_hamming_encoder_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hamming_encoder_fsm                                          |
// | Purpose  : Self-checking bench for hamming_encoder_fsm. It provides a      |
// |            byte memory, a cycle-indexed reference of the bus activity, a   |
// |            SECDED encoder/decoder written from the parity equations, and   |
// |            directed plus random runs.                                      |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_hamming_encoder_fsm;

  localparam int N       = 15;
  localparam int IN_B    = 0;
  localparam int OUT_B   = 30;
  localparam int AW      = 8;
  localparam int RUN_LEN = 5 * N;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, mem_wr_en;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;

  logic [7:0] mem [256];
  logic       tb_we   = 1'b0;
  logic [7:0] tb_addr = 8'h00;
  logic [7:0] tb_data = 8'h00;

  logic [7:0] in_lsw [N];
  logic [7:0] in_msw [N];

  int n_checks = 0;
  int n_errors = 0;
  // Cycles since the last accepted start. 0 means idle (never started or reset).
  int m_t = 0;

  always #5 Clk = ~Clk;

  hamming_encoder_fsm #(
    .NUM_WORDS (N),
    .IN_BASE   (IN_B),
    .OUT_BASE  (OUT_B),
    .AW        (AW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  // Synchronous byte memory. The bench preload port is used only while the DUT is idle.
  always @(posedge Clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en)  mem[mem_addr] <= mem_wr_data;
    else if (tb_we) mem[tb_addr]  <= tb_data;
  end

  // Encoder written directly from the parity equations.
  function automatic logic [15:0] enc(input logic [7:0] lsw, input logic [7:0] msw);
    logic [11:1] b;
    logic p8, p4, p2, p1, p0;
    b[8:1]  = lsw;
    b[11:9] = msw[2:0];
    p8 = ^b[11:5];
    p4 = b[11] ^ b[10] ^ b[9] ^ b[8] ^ b[4] ^ b[3] ^ b[2];
    p2 = b[11] ^ b[10] ^ b[7] ^ b[6] ^ b[4] ^ b[3] ^ b[1];
    p1 = b[11] ^ b[9]  ^ b[7] ^ b[5] ^ b[4] ^ b[2] ^ b[1];
    p0 = (^b) ^ p8 ^ p4 ^ p2 ^ p1;
    return {b[11], b[10], b[9], b[8], b[7], b[6], b[5], p8,
            b[4], b[3], b[2], p4, b[1], p2, p1, p0};
  endfunction

  // Syndrome decoder with single-error correction.
  function automatic logic [10:0] dec(input logic [15:0] c);
    logic [15:0] x;
    logic [3:0]  s;
    x = c;
    s = 4'd0;
    for (int i = 1; i < 16; i++) if (x[i]) s = s ^ 4'(i);
    if (^x) x[s] = ~x[s];
    return {x[15:9], x[7:5], x[3]};
  endfunction

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference sequencer, advanced on each active edge.
  always @(posedge Clk) begin
    if (!Reset)                                        m_t <= 0;
    else if (start && (m_t == 0 || m_t > RUN_LEN))     m_t <= 1;
    else if (m_t != 0 && m_t <= RUN_LEN)               m_t <= m_t + 1;
  end

  // Per-cycle comparison of every DUT output, sampled on the inactive edge.
  always @(negedge Clk) begin
    logic        e_busy, e_done, e_we;
    logic [7:0]  e_addr, e_wd;
    logic [15:0] code;
    int          w, ph;
    e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
    if (Reset && m_t != 0) begin
      if (m_t > RUN_LEN) begin
        e_done = 1'b1;
      end else begin
        w      = (m_t - 1) / 5;
        ph     = (m_t - 1) % 5;
        code   = enc(in_lsw[w], in_msw[w]);
        e_busy = 1'b1;
        case (ph)
          0: e_addr = 8'(IN_B + 2 * w);
          1: e_addr = 8'(IN_B + 2 * w + 1);
          3: begin e_we = 1'b1; e_addr = 8'(OUT_B + 2 * w);     e_wd = code[7:0];  end
          4: begin e_we = 1'b1; e_addr = 8'(OUT_B + 2 * w + 1); e_wd = code[15:8]; end
          default: ;
        endcase
      end
    end
    n_checks++;
    if ({busy, done, mem_wr_en, mem_addr, mem_wr_data} !== {e_busy, e_done, e_we, e_addr, e_wd}) begin
      n_errors++;
      $display("FAIL cycle_outputs t=%0d: got busy=%b done=%b we=%b addr=%h wd=%h, want busy=%b done=%b we=%b addr=%h wd=%h",
               m_t, busy, done, mem_wr_en, mem_addr, mem_wr_data, e_busy, e_done, e_we, e_addr, e_wd);
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic tb_write(input int a, input logic [7:0] d);
    tick();
    tb_we = 1'b1; tb_addr = 8'(a); tb_data = d;
    @(posedge Clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic load_inputs();
    for (int w = 0; w < N; w++) begin
      tb_write(IN_B + 2 * w, in_lsw[w]);
      tb_write(IN_B + 2 * w + 1, in_msw[w]);
    end
  endtask

  // Pulses start and returns cycles until done. inject > 0 pulses start again mid-run.
  task automatic run(input int inject, output int lat);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    lat = 1;
    while (!done && lat < 300) begin
      start = (inject != 0 && lat == inject);
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    logic [15:0] code;
    logic [10:0] data;
    int bad;
    for (int w = 0; w < N; w++) begin
      code = {mem[OUT_B + 2 * w + 1], mem[OUT_B + 2 * w]};
      check16($sformatf("%s_word%0d", tag, w), code, enc(in_lsw[w], in_msw[w]));
      data = {in_msw[w][2:0], in_lsw[w]};
      bad  = 0;
      for (int k = 0; k < 16; k++) if (dec(code ^ (16'd1 << k)) !== data) bad++;
      check16($sformatf("%s_flipdec%0d_badflips", tag, w), 16'(bad), 16'd0);
    end
  endtask

  initial begin
    int lat;
    logic [15:0] w2;

    // Reset, then pin the reference encoder with hand-computed words.
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    check16("pin_zero",    enc(8'h00, 8'h00), 16'h0000);
    check16("pin_b1",      enc(8'h01, 8'h00), 16'h000F);
    check16("pin_b11",     enc(8'h00, 8'hFC), 16'h8117);
    check16("pin_allones", enc(8'hFF, 8'h07), 16'hFFFF);

    // Run 1: the boundary patterns first, then random words, with a start pulse while busy.
    in_lsw[0] = 8'h00; in_msw[0] = 8'h00;
    in_lsw[1] = 8'h01; in_msw[1] = 8'h00;
    in_lsw[2] = 8'h00; in_msw[2] = 8'hFC;
    in_lsw[3] = 8'hFF; in_msw[3] = 8'h07;
    for (int w = 4; w < N; w++) begin
      in_lsw[w] = 8'($urandom);
      in_msw[w] = 8'($urandom);
    end
    load_inputs();
    run(20 + $urandom_range(0, 30), lat);
    check16("latency_run1", 16'(lat), 16'(RUN_LEN + 1));
    repeat (4) tick();
    check16("lit_zero",    {mem[OUT_B + 1], mem[OUT_B + 0]}, 16'h0000);
    check16("lit_b1",      {mem[OUT_B + 3], mem[OUT_B + 2]}, 16'h000F);
    check16("lit_b11",     {mem[OUT_B + 5], mem[OUT_B + 4]}, 16'h8117);
    check16("lit_allones", {mem[OUT_B + 7], mem[OUT_B + 6]}, 16'hFFFF);
    check_mem("run1");

    // Run 2: restart from DONE on the same data.
    run(0, lat);
    check16("latency_run2", 16'(lat), 16'(RUN_LEN + 1));
    check_mem("run2");

    // Run 3: reset during word 3 WR_LSW, with the output area preset to a marker.
    for (int w = 0; w < N; w++) begin
      in_lsw[w] = 8'($urandom);
      in_msw[w] = 8'($urandom);
    end
    load_inputs();
    for (int a = 0; a < 2 * N; a++) tb_write(OUT_B + a, 8'hA5);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    repeat (18) @(posedge Clk);
    #2;
    check16("pre_reset_wr_lsw", {7'd0, mem_wr_en, mem_addr}, {7'd0, 1'b1, 8'(OUT_B + 6)});
    Reset = 1'b0;
    #1;
    check16("reset_outputs_now", {6'd0, busy, done, mem_wr_en, mem_addr}, 16'h0000);
    check16("reset_wdata_now",   {8'd0, mem_wr_data}, 16'h0000);
    repeat (2) @(posedge Clk);
    #3 Reset = 1'b1;
    repeat (3) tick();
    w2 = enc(in_lsw[2], in_msw[2]);
    check16("partial_word2", {mem[OUT_B + 5], mem[OUT_B + 4]}, w2);
    check16("no_write_word3", {mem[OUT_B + 7], mem[OUT_B + 6]}, 16'hA5A5);

    // Run 4: a fresh start after reset reruns every word.
    run(0, lat);
    check16("latency_run4", 16'(lat), 16'(RUN_LEN + 1));
    check_mem("run4");
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
